// File: rtl/rate_counter_param.sv
// Modulo-MODULUS up/down counter advanced by a run-time selectable rate divider.
// Optional 7-segment decode of q is built when RATE_COUNTER_HEX_EN is defined.
module rate_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int DIV_WIDTH = 28,
    parameter int DIV1      = 49999999,
    parameter int DIV2      = 99999999,
    parameter int DIV3      = 199999999
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [1:0]                     freq_sel,
    input  logic                           par_load,
    input  logic [WIDTH-1:0]               load_val,
    input  logic                           up_down,
    output logic [WIDTH-1:0]               q,
    output logic                           tick,
    output logic                           wrap,
    output logic [7*((WIDTH+3)/4)-1:0]     hex_out
);

    localparam int NDIG = (WIDTH + 3) / 4;

    localparam logic [DIV_WIDTH-1:0] TERM1   = DIV_WIDTH'(DIV1);
    localparam logic [DIV_WIDTH-1:0] TERM2   = DIV_WIDTH'(DIV2);
    localparam logic [DIV_WIDTH-1:0] TERM3   = DIV_WIDTH'(DIV3);
    localparam logic [WIDTH-1:0]     Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]       MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [DIV_WIDTH-1:0] divcnt;
    logic [DIV_WIDTH-1:0] term;
    logic [1:0]           sel_q;
    logic                 rate_change;
    logic                 at_term;
    logic [WIDTH-1:0]     load_clamped;

    always_comb begin
        term = '0;
        case (freq_sel)
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            2'd3:    term = TERM3;
            default: term = '0;
        endcase
    end

    assign rate_change  = (freq_sel != sel_q);
    assign at_term      = (divcnt == term);
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? Q_MAX : load_val;

    assign tick = !reset && enable && !par_load && !rate_change
                  && ((freq_sel == 2'd0) || at_term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= '0;
            wrap   <= 1'b0;
            divcnt <= '0;
            sel_q  <= 2'd0;
        end else begin
            sel_q <= freq_sel;
            wrap  <= 1'b0;
            if (par_load) begin
                q      <= load_clamped;
                divcnt <= '0;
            end else if (rate_change) begin
                // restart the new period from zero so it runs in full
                divcnt <= '0;
            end else begin
                if (enable) begin
                    divcnt <= at_term ? '0 : divcnt + 1'b1;
                end
                if (tick) begin
                    if (up_down) begin
                        if (q == Q_MAX) begin
                            q    <= '0;
                            wrap <= 1'b1;
                        end else begin
                            q <= q + 1'b1;
                        end
                    end else begin
                        if (q == '0) begin
                            q    <= Q_MAX;
                            wrap <= 1'b1;
                        end else begin
                            q <= q - 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef RATE_COUNTER_HEX_EN
    // active-low segments, bit 0 = a ... bit 6 = g
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'b1111111;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [4*NDIG-1:0] q_ext;
    assign q_ext = (4*NDIG)'(q);

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        assign hex_out[7*k +: 7] = seg7(q_ext[4*k +: 4]);
    end
`else
    assign hex_out = '1;
`endif

endmodule

// File: tb/tb_rate_counter_param.sv
// Directed bench for rate_counter_param (small divider values, MODULUS=10),
// plus an 8-bit/256 instance for full-range load and hex decode.
module tb_rate_counter_param;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] freq_sel;
    logic       par_load;
    logic [3:0] load_val;
    logic       up_down;
    logic [3:0] q;
    logic       tick;
    logic       wrap;
    logic [6:0] hex_out;

    logic       h_enable;
    logic [1:0] h_freq_sel;
    logic       h_par_load;
    logic [7:0] h_load_val;
    logic       h_up_down;
    logic [7:0] h_q;
    logic       h_tick;
    logic       h_wrap;
    logic [13:0] h_hex_out;

    int vectors;
    int miscompares;

    rate_counter_param #(
        .WIDTH(4), .MODULUS(10), .DIV_WIDTH(28), .DIV1(3), .DIV2(5), .DIV3(9)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .freq_sel(freq_sel),
        .par_load(par_load), .load_val(load_val), .up_down(up_down),
        .q(q), .tick(tick), .wrap(wrap), .hex_out(hex_out)
    );

    rate_counter_param #(
        .WIDTH(8), .MODULUS(256), .DIV_WIDTH(28), .DIV1(3), .DIV2(5), .DIV3(9)
    ) u_hex (
        .clk(clk), .reset(reset), .enable(h_enable), .freq_sel(h_freq_sel),
        .par_load(h_par_load), .load_val(h_load_val), .up_down(h_up_down),
        .q(h_q), .tick(h_tick), .wrap(h_wrap), .hex_out(h_hex_out)
    );

`ifdef RATE_COUNTER_HEX_EN
    localparam logic [6:0]  HEX_Q1   = 7'b1111001;
    localparam logic [13:0] HEX_A5   = {7'b0001000, 7'b0010010};
    localparam logic [13:0] HEX_FF   = {7'b0001110, 7'b0001110};
`else
    localparam logic [6:0]  HEX_Q1   = 7'h7F;
    localparam logic [13:0] HEX_A5   = 14'h3FFF;
    localparam logic [13:0] HEX_FF   = 14'h3FFF;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        freq_sel    = 2'd0;
        par_load    = 1'b0;
        load_val    = 4'd0;
        up_down     = 1'b1;
        h_enable    = 1'b0;
        h_freq_sel  = 2'd0;
        h_par_load  = 1'b0;
        h_load_val  = 8'd0;
        h_up_down   = 1'b1;

        // reset state; tick held low despite enable & freq_sel=0
        #2;
        check("rst_q", 32'(q), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        @(posedge clk);
        #3;
        enable = 1'b0;
        reset  = 1'b0;

        // load q=7 (and A5 into the wide instance)
        par_load   = 1'b1;
        load_val   = 4'd7;
        h_par_load = 1'b1;
        h_load_val = 8'hA5;
        step();
        check("load7_q", 32'(q), 32'd7);
        check("hex_load_q", 32'(h_q), 32'hA5);
        check("hex_a5", 32'(h_hex_out), 32'(HEX_A5));
        h_load_val = 8'hFF;
        step();
        check("hex_noclamp_q", 32'(h_q), 32'hFF);
        check("hex_ff", 32'(h_hex_out), 32'(HEX_FF));
        h_par_load = 1'b0;

        // async reset between edges
        par_load = 1'b0;
        freq_sel = 2'd1;
        enable   = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check("async_q", 32'(q), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_hq", 32'(h_q), 32'd0);
        #2;
        reset = 1'b0;
        // sel_q resets to 0, so the first edge re-phases; four edges later q=1
        for (int i = 1; i <= 4; i++) begin
            step();
            check("rel_q0", 32'(q), 32'd0);
        end
        check("rel_tick", 32'(tick), 32'd1);
        step();
        check("rel_q1", 32'(q), 32'd1);
        check("rel_wrap", 32'(wrap), 32'd0);
        check("hex_q1", 32'(hex_out), 32'(HEX_Q1));

        // freq_sel=0 count up through the wrap
        freq_sel = 2'd0;
        par_load = 1'b1;
        load_val = 4'd8;
        step();
        check("up_load8", 32'(q), 32'd8);
        par_load = 1'b0;
        #1;
        check("up_tick", 32'(tick), 32'd1);
        step();
        check("up_q9", 32'(q), 32'd9);
        check("up_w9", 32'(wrap), 32'd0);
        step();
        check("up_q0", 32'(q), 32'd0);
        check("up_w0", 32'(wrap), 32'd1);
        step();
        check("up_q1", 32'(q), 32'd1);
        check("up_w1", 32'(wrap), 32'd0);

        // count down through zero, then freeze
        par_load = 1'b1;
        load_val = 4'd0;
        step();
        check("dn_load0", 32'(q), 32'd0);
        par_load = 1'b0;
        up_down  = 1'b0;
        step();
        check("dn_q9", 32'(q), 32'd9);
        check("dn_w9", 32'(wrap), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("frz_tick", 32'(tick), 32'd0);
            step();
            check("frz_q", 32'(q), 32'd9);
            check("frz_wrap", 32'(wrap), 32'd0);
        end
        enable = 1'b1;
        step();
        check("dn_q8", 32'(q), 32'd8);
        check("dn_w8", 32'(wrap), 32'd0);

        // divider phase must hold across a disabled stretch
        freq_sel = 2'd1;
        #1;
        check("rc_tick", 32'(tick), 32'd0);
        step();
        step();
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        step();
        check("dfrz_tick2", 32'(tick), 32'd0);
        step();
        check("dfrz_tick3", 32'(tick), 32'd1);
        step();
        check("dfrz_q7", 32'(q), 32'd7);

        // load clamp and load-over-tick priority
        freq_sel = 2'd0;
        up_down  = 1'b1;
        par_load = 1'b1;
        load_val = 4'hC;
        step();
        check("clamp_c", 32'(q), 32'd9);
        check("clamp_wrap", 32'(wrap), 32'd0);
        load_val = 4'd10;
        step();
        check("clamp_10", 32'(q), 32'd9);
        load_val = 4'd3;
        #1;
        check("ld_tick", 32'(tick), 32'd0);
        step();
        check("ld_q3", 32'(q), 32'd3);
        check("ld_wrap", 32'(wrap), 32'd0);
        enable   = 1'b0;
        load_val = 4'd5;
        step();
        check("ld_dis_q5", 32'(q), 32'd5);

        // rate change 1->3 at divcnt=2
        enable   = 1'b1;
        load_val = 4'd0;
        freq_sel = 2'd1;
        step();
        par_load = 1'b0;
        step();
        step();
        freq_sel = 2'd3;
        #1;
        check("rc13_tick", 32'(tick), 32'd0);
        step();
        check("rc13_q", 32'(q), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            check("rc13_tk", 32'(tick), 32'(k == 10));
            step();
            check("rc13_qk", 32'(q), (k == 10) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
